// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: bus widths, EXE->MEM field layout and response-state encodings for the MEM stage.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 81;
    localparam int MS_TO_WS_BUS_WD = 70;
    localparam int MS_FWD_BUS_WD   = 39;

    typedef enum logic [1:0] {
        MS_NOREQ = 2'd0,
        MS_WAIT  = 2'd1,
        MS_HELD  = 2'd2
    } ms_state_e;

    typedef struct packed {
        logic        mem_req;
        logic        ld_w;
        logic        ld_b;
        logic        ld_bu;
        logic        ld_h;
        logic        ld_hu;
        logic        st_w;
        logic        st_b;
        logic        st_h;
        logic        res_from_mem;
        logic        mem_we;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_bus_t;

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: selects and sign/zero-extends the loaded byte or half from a read-data word.
module mem_load_align (
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic        ld_w,
    input  logic        ld_b,
    input  logic        ld_bu,
    input  logic        ld_h,
    input  logic        ld_hu,
    output logic [31:0] value
);
    logic [7:0]  b;
    logic [15:0] h;

    assign b = rdata[{addr_lo, 3'b000} +: 8];
    assign h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        value = ld_w  ? rdata :
                ld_b  ? {{24{b[7]}}, b} :
                ld_bu ? {24'b0, b} :
                ld_h  ? {{16{h[15]}}, h} :
                ld_hu ? {16'b0, h} : rdata;
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: waits for the data_sram response, aligns load data and forwards results to WB and ID.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    output logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus
);
    ms_state_e   state, state_next;
    es_bus_t     ms_bus;
    logic        ms_valid;
    logic        ms_ready_go;
    logic        es_mem_req;
    logic        capture;
    logic [31:0] rdata_buf;
    logic [31:0] rdata_sel;
    logic [31:0] load_data;
    logic [31:0] final_result;
    logic        fwd_valid;
    logic        unused_ok;

    assign es_mem_req  = es_to_ms_bus[ES_TO_MS_BUS_WD-1];
    assign ms_ready_go = (state == MS_WAIT) ? data_sram_data_ok : 1'b1;
    assign ms_allowin  = !ms_valid || (ms_ready_go && ws_allowin);
    assign capture     = ms_valid && (state == MS_WAIT) && data_sram_data_ok && !ws_allowin;

    always_comb begin
        state_next = state;
        if (ms_allowin)
            state_next = (es_to_ms_valid && es_mem_req) ? MS_WAIT : MS_NOREQ;
        else if (capture)
            state_next = MS_HELD;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= MS_NOREQ;
            ms_valid  <= 1'b0;
            ms_bus    <= '0;
            rdata_buf <= '0;
        end else begin
            state <= state_next;
            if (ms_allowin)
                ms_valid <= es_to_ms_valid;
            if (es_to_ms_valid && ms_allowin)
                ms_bus <= es_to_ms_bus;
            if (capture)
                rdata_buf <= data_sram_rdata;
        end
    end

    // Once HELD, the sram bus may carry anything; only the buffered word is trusted.
    assign rdata_sel = (state == MS_HELD) ? rdata_buf : data_sram_rdata;

    mem_load_align u_align (
        .rdata   (rdata_sel),
        .addr_lo (ms_bus.alu_result[1:0]),
        .ld_w    (ms_bus.ld_w),
        .ld_b    (ms_bus.ld_b),
        .ld_bu   (ms_bus.ld_bu),
        .ld_h    (ms_bus.ld_h),
        .ld_hu   (ms_bus.ld_hu),
        .value   (load_data)
    );

    assign final_result   = ms_bus.res_from_mem ? load_data : ms_bus.alu_result;
    assign ms_to_ws_valid = ms_valid && ms_ready_go;
    assign ms_to_ws_bus   = {ms_bus.gr_we && ms_valid, ms_bus.dest, final_result, ms_bus.pc};
    assign fwd_valid      = ms_valid && ms_bus.gr_we && (ms_bus.dest != 5'd0);
    assign ms_fwd_bus     = {fwd_valid && ms_bus.res_from_mem && !ms_ready_go, fwd_valid, ms_bus.dest, final_result};
    assign unused_ok      = ^{ms_bus.st_w, ms_bus.st_b, ms_bus.st_h, ms_bus.mem_we};
endmodule
